fifo_sync_param: RTL

- Parametrised single-clock FIFO. It is the next-generation replacement for the fixed 8x12 transaction-layer FIFO.
- Width, depth and almost thresholds are generic.
- Push and pop in the same cycle are fully supported.
- Provides an exact occupancy count, full/empty flags, sticky overflow/underflow error flags, and a registered read-data valid strobe.
- Instantiated per virtual-channel/transaction-type queue in the PCIe transaction layer.

---
 rtl/fifo_pkg.sv | 43 ++++
 rtl/fifo_dpram.sv | 52 +++++
 rtl/fifo_sync_param.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : shared defaults, width helper and flag bundle for fifo_sync_param
// Revision : 1.0
// ============================================================================
package fifo_pkg;

    localparam int FIFO_DW    = 12;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AF    = 6;
    localparam int FIFO_AE    = 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Ceiling log2, usable in parameter defaults.
    function automatic int fifo_clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic fifo_flags_t fifo_flags(input int cnt, input int depth,
                                               input int af, input int ae);
        fifo_flags_t f;
        f.full         = (cnt == depth);
        f.empty        = (cnt == 0);
        f.almost_full  = (cnt >= af);
        f.almost_empty = (cnt <= ae);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_dpram.sv
`default_nettype none
// ============================================================================
// fifo_dpram : simple dual-port RAM, one write port, one registered read port
// Revision   : 1.0
// ============================================================================
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DW,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_W     = fifo_clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read samples the array before this edge's write lands: read-first on a collision.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// fifo_sync_param : parametrised single-clock FIFO with exact count and flags
// Revision        : 1.0
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = FIFO_DW,
    parameter int DEPTH        = FIFO_DEPTH,
    parameter int ALMOST_FULL  = FIFO_AF,
    parameter int ALMOST_EMPTY = FIFO_AE,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("fifo_sync_param: DEPTH must be a power of 2 and >= 2");
    end
    if ((ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_chk_af
        $error("fifo_sync_param: ALMOST_FULL out of range 1..DEPTH");
    end
    if ((ALMOST_EMPTY < 0) || (ALMOST_EMPTY > DEPTH - 1)) begin : g_chk_ae
        $error("fifo_sync_param: ALMOST_EMPTY out of range 0..DEPTH-1");
    end
    if ((ADDR_W != $clog2(DEPTH)) || (CNT_W != $clog2(DEPTH + 1))) begin : g_chk_widths
        $error("fifo_sync_param: ADDR_W/CNT_W are derived and must not be overridden");
    end

    localparam fifo_flags_t C_RESET_FLAGS = fifo_flags(0, DEPTH, ALMOST_FULL, ALMOST_EMPTY);

    logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]  count_d, count_q;
    fifo_flags_t       flags_d, flags_q;
    logic              overflow_d, overflow_q;
    logic              underflow_d, underflow_q;
    logic              valid_d, valid_q;
    logic              push_ok;
    logic              pop_ok;
    logic              ram_we;
    logic              ram_re;

    // Acceptance uses registered flags only; a full FIFO takes a push only alongside a pop.
    always_comb begin
        pop_ok      = pop & ~flags_q.empty;
        push_ok     = push & (~flags_q.full | pop_ok);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flags follow the next count so they never lag the count output.
        flags_d     = fifo_flags(32'(count_d), DEPTH, ALMOST_FULL, ALMOST_EMPTY);
        overflow_d  = overflow_q  | (push & ~push_ok);
        underflow_d = underflow_q | (pop & ~pop_ok);
        valid_d     = pop_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flags_q     <= C_RESET_FLAGS;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            valid_q     <= valid_d;
        end
    end

    assign ram_we = push_ok & ~reset;
    assign ram_re = pop_ok & ~reset;

    fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign data_valid   = valid_q;
    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
`default_nettype wire
